// File: rtl/spi_cmd_master_pkg.sv
// Shared types and constants for the SPI command initiator.
// Op codes match the slave's frame decode; counters are sized for the longest phase.
package spi_cmd_master_pkg;

  localparam int CMD_W          = 10;
  localparam int DATA_W         = 8;
  localparam int CNT_W          = 4;
  localparam int TURNAROUND_DEF = 2;
  localparam int GAP_DEF        = 1;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    TURN  = 3'd3,
    RECV  = 3'd4,
    END   = 3'd5
  } state_e;

  // Only the rd-data op turns the line around and expects a reply byte.
  function automatic logic is_rd_data(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_W-1 -: 2] == OP_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// Command port, SPI pins and read-reply outputs of the SPI command initiator.
// master = initiator side, slave = host / serial-slave side.
interface spi_cmd_master_if;
  import spi_cmd_master_pkg::*;

  logic              cmd_valid;
  logic [CMD_W-1:0]  cmd_data;
  logic              cmd_ready;
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_data, MISO,
    output cmd_ready, SS_n, MOSI, rd_data, rd_valid, busy
  );

  modport slave (
    output cmd_valid, cmd_data, MISO,
    input  cmd_ready, SS_n, MOSI, rd_data, rd_valid, busy
  );

endinterface

// File: rtl/spi_cmd_master.sv
// Serialises 10-bit {op,byte} commands onto SS_n/MOSI and captures the rd-data reply from MISO.
// Frame: 12+GAP cycles (20+TURNAROUND+GAP for rd-data); cmd_ready only in IDLE, so cmds stall outside it.
module spi_cmd_master
  import spi_cmd_master_pkg::*;
#(
  parameter int TURNAROUND = TURNAROUND_DEF,
  parameter int GAP        = GAP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_cmd_master_if.master bus
);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CMD_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              rd_op_q, rd_op_d;
  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              cmd_acc;

  assign cmd_acc = (state_q == IDLE) && bus.cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_op_q    <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_op_q    <= rd_op_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Every timed state clears the counter on exit so each phase counts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_acc) state_d = START;
      end
      START: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = rd_op_q ? TURN : END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = RECV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECV: begin
        if (cnt_q == RECV_LAST) begin
          state_d = END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      END: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_op_d    = rd_op_q;
    ss_n_d     = 1'b1;
    mosi_d     = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    busy_d     = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          tx_d    = bus.cmd_data;
          rd_op_d = is_rd_data(bus.cmd_data);
        end
      end
      // START presents the select bit early so the slave sees it as SS_n falls.
      START: begin
        ss_n_d = 1'b0;
        mosi_d = tx_q[CMD_W-1];
      end
      SHIFT: begin
        ss_n_d = 1'b0;
        mosi_d = tx_q[CMD_W-1];
        tx_d   = {tx_q[CMD_W-2:0], 1'b0};
      end
      TURN: begin
        ss_n_d = 1'b0;
      end
      RECV: begin
        ss_n_d = 1'b0;
        rx_d   = {rx_q[DATA_W-2:0], bus.MISO};
      end
      END: begin
        if (cnt_q == '0 && rd_op_q) begin
          rd_data_d  = rx_q;
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        ss_n_d = 1'b1;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: cycle-indexed frame model plus a RAM-backed serial slave model.
module tb_spi_cmd_master;
  import spi_cmd_master_pkg::*;

  localparam int TA = 2;
  localparam int GP = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  spi_cmd_master_if bus ();

  spi_cmd_master #(.TURNAROUND(TA), .GAP(GP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Slave/RAM model and frame expectations, all in absolute cycle numbers.
  logic [7:0]       ram [256];
  logic [7:0]       wa = '0, ra = '0, reply = '0, exp_rd = '0;
  logic [CMD_W-1:0] cur = '0;
  bit               cur_rd = 1'b0, have_frame = 1'b0, idle_next = 1'b1;
  int               cyc = 0, f0 = 0, busy_end = 0, rise_k = 0;
  int               acc_count = 0, prev_acc = 0, last_acc = 0;
  logic [10:0]      mosi_trace = '0;
  int               ss_low = 0, ss_low_last = 0, rv_k = -1, rv_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : model
    int k;
    bit e_busy, e_ss, e_mosi, e_rv;
    if (!rst_n) begin
      have_frame = 1'b0;
      exp_rd     = '0;
    end else begin
      k      = cyc - f0;
      e_busy = have_frame && k >= 0 && cyc <= busy_end;
      e_ss   = !(have_frame && k >= 1 && k < rise_k);
      e_mosi = 1'b0;
      if (have_frame && k == 1) e_mosi = cur[CMD_W-1];
      else if (have_frame && k >= 2 && k <= 11) e_mosi = cur[11-k];
      e_rv = have_frame && cur_rd && k == rise_k;
      if (e_rv) exp_rd = reply;
      if (have_frame && cur_rd && k >= 11 + TA && k <= 18 + TA) bus.MISO = reply[18+TA-k];
      else bus.MISO = 1'($urandom);
      chk("SS_n", bus.SS_n, e_ss);
      chk("MOSI", bus.MOSI, e_mosi);
      chk("busy", bus.busy, e_busy);
      chk("cmd_ready", bus.cmd_ready, !e_busy);
      chk("rd_valid", bus.rd_valid, e_rv);
      chk("rd_data", bus.rd_data, exp_rd);
      if (!bus.SS_n) ss_low++;
      if (bus.rd_valid) begin rv_k = k; rv_pulses++; end
      if (have_frame && k >= 1 && k <= 11) mosi_trace[11-k] = bus.MOSI;
      if (!e_busy && bus.cmd_valid) begin
        acc_count++;
        prev_acc    = last_acc;
        last_acc    = cyc;
        f0          = cyc + 1;
        cur         = bus.cmd_data;
        cur_rd      = (cur[9:8] == 2'b11);
        rise_k      = cur_rd ? 20 + TA : 12;
        busy_end    = f0 + (cur_rd ? 18 + TA + GP : 10 + GP);
        have_frame  = 1'b1;
        ss_low_last = ss_low;
        ss_low      = 0;
        rv_pulses   = 0;
        rv_k        = -1;
        case (cur[9:8])
          2'b00:   wa = cur[7:0];
          2'b01:   ram[wa] = cur[7:0];
          2'b10:   ra = cur[7:0];
          default: reply = ram[ra];
        endcase
      end
    end
    cyc++;
    idle_next = !have_frame || cyc > busy_end;
  end

  task automatic send(input logic [CMD_W-1:0] c);
    int n0;
    n0            = acc_count;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (acc_count != n0) break;
    end
    if (acc_count == n0) begin
      tests++; fails++;
      $display("FAIL send_timeout cmd=0x%0h not accepted", c);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!idle_next && n < 200) begin @(posedge clk); #1; n++; end
    if (!idle_next) begin
      tests++; fails++;
      $display("FAIL idle_timeout: frame never ended");
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    logic [1:0] op;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);

    // Reset values while held, ready after release
    #23;
    chk("rst_SS_n", bus.SS_n, 1'b1);
    chk("rst_MOSI", bus.MOSI, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);

    // Write-address frame and back-to-back period
    send(10'h0A5);
    send(10'h1FF);
    chk("wr_mosi_bits", mosi_trace, 11'h0A5);
    chk("wr_ss_low_cycles", ss_low_last, 11);
    chk("b2b_period", last_acc - prev_acc, 13);
    wait_idle();

    // Write then read back through the slave RAM
    send(10'h010); send(10'h13C); send(10'h210); send(10'h300);
    wait_idle();
    chk("rd_3C_data", bus.rd_data, 8'h3C);
    chk("rd_valid_latency", rv_k, 20 + TA);
    chk("rd_valid_pulses", rv_pulses, 1);

    send(10'h055); send(10'h1B2); send(10'h255); send(10'h300);
    wait_idle();
    chk("rd_B2_data", bus.rd_data, 8'hB2);

    // cmd_valid held through a frame with changing data
    send(10'h0C3);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (idle_next) break;
      bus.cmd_data = 10'($urandom);
      @(posedge clk); #1;
    end
    bus.cmd_data = 10'h15A;
    n = acc_count;
    for (int i = 0; i < 50; i++) begin
      if (acc_count != n) break;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("held_valid_mosi", mosi_trace, 11'h15A);

    // Reset during RECV bit 4
    send(10'h300);
    n = 0;
    while ((cyc - f0) != 11 + TA + 4 && n < 100) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    #1;
    chk("midrst_SS_n", bus.SS_n, 1'b1);
    chk("midrst_rd_valid", bus.rd_valid, 1'b0);
    chk("midrst_rd_data", bus.rd_data, 8'h00);
    chk("midrst_busy", bus.busy, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send(10'h300);
    wait_idle();
    chk("post_rst_rd_data", bus.rd_data, 8'hB2);
    chk("post_rst_pulses", rv_pulses, 1);

    // Randomised command stream
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      send({op, 8'($urandom)});
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
